// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter datapath and its stream collector.
// Holds the default geometry, derived widths, the element type and the
// collector FSM encoding. No ports; imported by the collector files.
package sorter_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_MAX_ARRAY_SIZE = 16;

    // Count must reach MAX_ARRAY_SIZE, index only MAX_ARRAY_SIZE-1.
    localparam int SIZE_W = $clog2(DEFAULT_MAX_ARRAY_SIZE + 1);
    localparam int ADDR_W = $clog2(DEFAULT_MAX_ARRAY_SIZE);

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } collector_state_t;

endpackage

// File: rtl/collector_mem.sv
// collector_mem: DEPTH x DATA_WIDTH register file, one write port and one
// registered read port.
// Ports:
//   clk, reset         clock, synchronous active-high reset (clears storage)
//   wr_en/addr/data    write port, takes effect on the rising edge
//   rd_addr, rd_hit    read index; rd_hit=0 forces the read result to zero
//   rd_data            registered read data (1-cycle latency). A write to the
//                      addressed entry on the same edge returns the old value.
module collector_mem
    import sorter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_MAX_ARRAY_SIZE,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en)
                mem_q[wr_addr] <= wr_data;
            rd_data <= rd_hit ? mem_q[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/sorted_stream_collector.sv
// sorted_stream_collector: receive end of the sorter output stream.
// Captures each in_valid burst, checks it is non-decreasing and matches the
// advertised size, tracks first/last element, and offers a registered
// random-read port into the captured array.
// Optional build macro COLLECTOR_CHECKSUM_EN adds a wrap-around running sum
// output (checksum) of the stored beats of the current burst.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous flush to IDLE (wins over in_valid)
//   in_data/valid   stream beat; a burst is consecutive valid cycles
//   expected_size   advertised count, latched on the first beat
//   rd_addr/rd_data read port, 1-cycle latency, 0 beyond count
//   count,done,busy burst progress
//   min_out/max_out first / last stored element
//   order_error, size_error, overflow   burst status flags
//   checksum        (COLLECTOR_CHECKSUM_EN only) running sum
module sorted_stream_collector
    import sorter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int MAX_ARRAY_SIZE = DEFAULT_MAX_ARRAY_SIZE,
    localparam int CW            = $clog2(MAX_ARRAY_SIZE + 1),
    localparam int AW            = $clog2(MAX_ARRAY_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [CW-1:0]         expected_size,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  done,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] min_out,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic                  order_error,
    output logic                  size_error,
`ifdef COLLECTOR_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  overflow
);

    collector_state_t state_q, state_d;

    logic [CW-1:0]         count_q, exp_q;
    logic [DATA_WIDTH-1:0] min_q, max_q;
    logic                  oerr_q, serr_q, ovf_q;

    logic start, beat, store, drop, burst_end, full;
    logic wr_en;
    logic [AW-1:0] wr_addr;

    assign full      = (count_q >= CW'(MAX_ARRAY_SIZE));
    assign start     = !clear && in_valid && (state_q != COLLECT);
    assign beat      = !clear && in_valid && (state_q == COLLECT);
    assign store     = beat && !full;
    assign drop      = beat && full;
    assign burst_end = !clear && !in_valid && (state_q == COLLECT);

    // Start always writes slot 0; otherwise the next free slot. count_q is
    // below MAX here, so its low bits are a valid index.
    assign wr_en   = start || store;
    assign wr_addr = start ? '0 : count_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (in_valid)  state_d = COLLECT;
                COLLECT:    if (!in_valid) state_d = DONE;
                default:                   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
            exp_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            oerr_q  <= 1'b0;
            serr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            count_q <= CW'(1);
            exp_q   <= expected_size;
            min_q   <= in_data;
            max_q   <= in_data;
            oerr_q  <= 1'b0;
            serr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (store) begin
            count_q <= count_q + CW'(1);
            max_q   <= in_data;
            // max_q is always the previously stored element.
            if (in_data < max_q)
                oerr_q <= 1'b1;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (burst_end) begin
            serr_q <= (count_q != exp_q);
        end
    end

`ifdef COLLECTOR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset || clear) csum_q <= '0;
        else if (start)     csum_q <= in_data;
        else if (store)     csum_q <= csum_q + in_data;
    end

    assign checksum = csum_q;
`endif

    // Gate on the pre-edge count so entries beyond the burst (including
    // stale data after clear) always read as zero.
    collector_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_ARRAY_SIZE)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_hit  (CW'(rd_addr) < count_q),
        .rd_data (rd_data)
    );

    assign count       = count_q;
    assign busy        = (state_q == COLLECT);
    assign done        = (state_q == DONE);
    assign min_out     = min_q;
    assign max_out     = max_q;
    assign order_error = oerr_q;
    assign size_error  = serr_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/sorted_stream_collector.md
Name: sorted_stream_collector

Overview:
- Receive end of the sorter's output stream.
- Captures each valid burst of sorted data into local storage and checks that it is non-decreasing and matches the advertised size.
- Tracks min/max and exposes the captured array through a registered random-read port for downstream logic and debug.
- Sits directly after dynamic_array_sorter: in_data/in_valid driven by sorted_data_out/valid_out, expected_size driven by array_size.

Parameters:
- DATA_WIDTH, 32, width of each element.
- MAX_ARRAY_SIZE, 16, maximum number of stored elements.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of the captured array and all flags.
- in_data  input  DATA_WIDTH  stream element.
- in_valid  input  1  in_data valid this cycle; a burst is consecutive high cycles.
- expected_size  input  $clog2(MAX_ARRAY_SIZE+1)  advertised element count, sampled on the first beat of a burst.
- rd_addr  input  $clog2(MAX_ARRAY_SIZE)  read index.
- rd_data  output  DATA_WIDTH  registered read data.
- count  output  $clog2(MAX_ARRAY_SIZE+1)  elements stored in the current burst.
- done  output  1  burst complete, contents stable.
- busy  output  1  burst in progress.
- min_out  output  DATA_WIDTH  first stored element of the burst.
- max_out  output  DATA_WIDTH  last stored element of the burst.
- order_error  output  1  sticky: a beat was smaller than its predecessor.
- size_error  output  1  set at burst end when count != latched expected_size.
- overflow  output  1  sticky: a beat arrived with count == MAX_ARRAY_SIZE.

Behaviour:
- Reset values: every output is 0, including rd_data and all storage. State is IDLE.
- FSM states are IDLE, COLLECT and DONE.
- IDLE or DONE, in_valid=1:
  - Start a new burst: store in_data at index 0, count=1, min_out=max_out=in_data.
  - Latch expected_size and clear order_error, size_error and overflow.
  - busy=1, done=0, go to COLLECT.
- COLLECT, in_valid=1, count<MAX_ARRAY_SIZE:
  - Store at index count, count+1, max_out=in_data.
  - If in_data < previous stored element (unsigned compare), set order_error. Equal values are legal.
- COLLECT, in_valid=1, count==MAX_ARRAY_SIZE: drop the beat, set overflow, count holds.
- COLLECT, in_valid=0: burst ends.
  - Go to DONE, busy=0, done=1.
  - size_error = (count != latched size), registered on that same edge.
- DONE holds all contents and flags until clear or a new burst.
- clear: returns to IDLE, count=0, all flags and min/max=0. Storage contents are don't-care but unreadable.
- clear and in_valid in the same cycle: clear wins and the beat is dropped.
- Reset mid-burst behaves identically to power-on reset.
- Read port:
  - rd_data is registered, 1-cycle latency from rd_addr.
  - Returns 0 when rd_addr >= count.
  - Legal in any state; a same-cycle write to the addressed entry returns the old value.
- Status outputs (count, min/max, flags) update on the edge that consumes the beat, so they are visible the cycle after.

Optional Feature:
- COLLECTOR_CHECKSUM_EN defined:
  - Adds output checksum [DATA_WIDTH], the running wrap-around modulo-2^DATA_WIDTH sum of all stored (non-dropped) beats of the current burst.
  - Cleared by reset, clear and burst start.
- Undefined: the port and its adder are absent.

Decomposition:
- Shared package sorter_pkg:
  - DATA_WIDTH and MAX_ARRAY_SIZE defaults.
  - SIZE_W = $clog2(MAX_ARRAY_SIZE+1), ADDR_W = $clog2(MAX_ARRAY_SIZE).
  - data_t typedef.
  - FSM enum collector_state_t {IDLE, COLLECT, DONE}.
- One sub-module is natural: collector_mem, a MAX_ARRAY_SIZE x DATA_WIDTH register file with one write port and one registered read port.

Test Plan:
- Burst 5,17,32,42,61,93 with expected_size=6, then in_valid low:
  - count=6, min_out=5, max_out=93, done=1.
  - order_error=0, size_error=0.
  - rd_addr 0..5 returns 5,17,32,42,61,93; rd_addr 6 returns 0.
- Burst 10,20,15 with expected_size=3: order_error=1 after third beat, count=3, size_error=0.
- 17 beats 1..17 with expected_size=16: count=16, overflow=1, rd_addr 15 returns 16, size_error=0.
- Burst 25,50,75,100 with expected_size=5: done=1, size_error=1. A following burst 7 with size 1 clears size_error, count=1.
- clear asserted together with the 3rd beat of 1,2,3: state IDLE, count=0, done=0, beat discarded. Repeat with reset mid-burst: same result.
- With COLLECTOR_CHECKSUM_EN: burst 0xFFFFFFFF,0xFFFFFFFF gives checksum 0xFFFFFFFE.
